// File: rtl/rv32_pkg.sv
// Shared RV32 integer-register types and constants used by the register bank.
// Also provides the popcount helper used for the busy counter.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;
  typedef logic [5:0]            busy_cnt_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  function automatic busy_cnt_t countBusy(input logic [NREGS-1:0] v);
    busy_cnt_t n;
    n = '0;
    for (int i = 0; i < NREGS; i++) begin
      n = n + busy_cnt_t'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_bank_if.sv
// Decode/writeback side bundle of the integer register bank.
// master = decode + writeback pipeline, slave = regfile_bank.
interface regfile_bank_if;
  import rv32_pkg::*;

  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  xword_t    rs1_data;
  xword_t    rs2_data;
  logic      rs1_busy;
  logic      rs2_busy;
  logic      wr_en;
  reg_addr_t wr_addr;
  xword_t    wr_data;
  logic      issue_en;
  reg_addr_t issue_rd;
  busy_cnt_t busy_count;

  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_count
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_count
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational 32:1 read port with x0 forced to zero.
// With REGFILE_BYPASS_EN defined, a same-cycle writeback to the read address is forwarded.
module regfile_read_port
  import rv32_pkg::*;
(
`ifdef REGFILE_BYPASS_EN
  input  logic                        i_wr_en,
  input  reg_addr_t                   i_wr_addr,
  input  xword_t                      i_wr_data,
  input  logic                        i_issue_en,
  input  reg_addr_t                   i_issue_rd,
`endif
  input  logic [NREGS-1:0][XLEN-1:0]  i_regs,
  input  logic [NREGS-1:0]            i_busy,
  input  reg_addr_t                   i_addr,
  output xword_t                      o_data,
  output logic                        o_busy
);

  always_comb begin
    o_data = (i_addr == REG_ZERO) ? '0 : i_regs[i_addr];
    o_busy = i_busy[i_addr];
`ifdef REGFILE_BYPASS_EN
    // A retiring write clears busy unless a new producer for the same register issues now.
    if (i_wr_en && (i_wr_addr == i_addr) && (i_addr != REG_ZERO)) begin
      o_data = i_wr_data;
      o_busy = i_issue_en && (i_issue_rd == i_addr);
    end
`endif
  end

endmodule

// File: rtl/regfile_bank.sv
// RV32 integer register bank: 32 x XLEN storage, two read ports, busy scoreboard.
// Optional same-cycle write forwarding is built when REGFILE_BYPASS_EN is defined.
module regfile_bank
  import rv32_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  regfile_bank_if.slave  bus
);

  logic [NREGS-1:0][XLEN-1:0] r_regs;
  logic [NREGS-1:0]           r_busy;
  busy_cnt_t                  r_busyCount;
  logic [NREGS-1:0]           w_busyNext;

  // Issue sets busy and wins over a retiring write to the same register.
  always_comb begin
    w_busyNext = r_busy;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.issue_en && (bus.issue_rd == reg_addr_t'(r))) begin
        w_busyNext[r] = 1'b1;
      end else if (bus.wr_en && (bus.wr_addr == reg_addr_t'(r))) begin
        w_busyNext[r] = 1'b0;
      end
    end
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs      <= '0;
      r_busy      <= '0;
      r_busyCount <= '0;
    end else begin
      if (bus.wr_en && (bus.wr_addr != REG_ZERO)) begin
        r_regs[bus.wr_addr] <= bus.wr_data;
      end
      r_busy      <= w_busyNext;
      r_busyCount <= countBusy(w_busyNext);
    end
  end

  assign bus.busy_count = r_busyCount;

  regfile_read_port u_rs1 (
`ifdef REGFILE_BYPASS_EN
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_data  (bus.wr_data),
    .i_issue_en (bus.issue_en),
    .i_issue_rd (bus.issue_rd),
`endif
    .i_regs     (r_regs),
    .i_busy     (r_busy),
    .i_addr     (bus.rs1_addr),
    .o_data     (bus.rs1_data),
    .o_busy     (bus.rs1_busy)
  );

  regfile_read_port u_rs2 (
`ifdef REGFILE_BYPASS_EN
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_data  (bus.wr_data),
    .i_issue_en (bus.issue_en),
    .i_issue_rd (bus.issue_rd),
`endif
    .i_regs     (r_regs),
    .i_busy     (r_busy),
    .i_addr     (bus.rs2_addr),
    .o_data     (bus.rs2_data),
    .o_busy     (bus.rs2_busy)
  );

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: directed scenarios plus a randomized run
// against an array-based reference model. Honors REGFILE_BYPASS_EN when defined.
module tb_regfile_bank;
  import rv32_pkg::*;

  logic clk;
  logic rst;
  int   nVectors;
  int   nMiscompares;

  xword_t mRegs [32];
  bit     mBusy [32];

  regfile_bank_if bus_if ();

  regfile_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected read value as decode should see it this cycle.
  function automatic xword_t expData(input reg_addr_t a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus_if.wr_en && bus_if.wr_addr == a) return bus_if.wr_data;
`endif
    return mRegs[a];
  endfunction

  function automatic logic expBusy(input reg_addr_t a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus_if.wr_en && bus_if.wr_addr == a) return bus_if.issue_en && bus_if.issue_rd == a;
`endif
    return mBusy[a];
  endfunction

  function automatic int expCount();
    int n;
    n = 0;
    foreach (mBusy[i]) n += int'(mBusy[i]);
    return n;
  endfunction

  // Advance one clock, updating the model from the inputs presented at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (mRegs[i]) begin
        mRegs[i] = '0;
        mBusy[i] = 1'b0;
      end
    end else begin
      if (bus_if.wr_en && bus_if.wr_addr != 0) begin
        mRegs[bus_if.wr_addr] = bus_if.wr_data;
        mBusy[bus_if.wr_addr] = 1'b0;
      end
      if (bus_if.issue_en && bus_if.issue_rd != 0) mBusy[bus_if.issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    bus_if.wr_en    = 1'b0;
    bus_if.wr_addr  = '0;
    bus_if.wr_data  = '0;
    bus_if.issue_en = 1'b0;
    bus_if.issue_rd = '0;
  endtask

  task automatic test_reset();
    idle();
    bus_if.rs1_addr = '0;
    bus_if.rs2_addr = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus_if.rs1_addr = reg_addr_t'(i);
      bus_if.rs2_addr = reg_addr_t'(31 - i);
      #1;
      nVectors++;
      if (bus_if.rs1_data !== 32'h0 || bus_if.rs2_data !== 32'h0) begin
        nMiscompares++;
        $display("[TB] FAIL reset_data addr %0d: rs1=%h rs2=%h expected 0", i, bus_if.rs1_data, bus_if.rs2_data);
      end
      nVectors++;
      if (bus_if.rs1_busy !== 1'b0 || bus_if.rs2_busy !== 1'b0) begin
        nMiscompares++;
        $display("[TB] FAIL reset_busy addr %0d: rs1=%b rs2=%b expected 0", i, bus_if.rs1_busy, bus_if.rs2_busy);
      end
    end
    nVectors++;
    if (bus_if.busy_count !== 6'd0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_count got %0d expected 0", bus_if.busy_count);
    end
    tick();
  endtask

  task automatic test_write();
    bus_if.wr_en = 1'b1; bus_if.wr_addr = 5'd5; bus_if.wr_data = 32'hDEADBEEF;
    tick();
    idle();
    bus_if.rs1_addr = 5'd5;
    #1;
    nVectors++;
    if (bus_if.rs1_data !== 32'hDEADBEEF) begin
      nMiscompares++;
      $display("[TB] FAIL write_r5 got %h expected deadbeef", bus_if.rs1_data);
    end
    bus_if.wr_en = 1'b1; bus_if.wr_addr = 5'd0; bus_if.wr_data = 32'h1234;
    tick();
    idle();
    bus_if.rs1_addr = 5'd0;
    bus_if.rs2_addr = 5'd0;
    #1;
    nVectors++;
    if (bus_if.rs1_data !== 32'h0 || bus_if.rs2_data !== 32'h0) begin
      nMiscompares++;
      $display("[TB] FAIL write_x0 rs1=%h rs2=%h expected 0", bus_if.rs1_data, bus_if.rs2_data);
    end
  endtask

  task automatic test_scoreboard();
    bus_if.issue_en = 1'b1; bus_if.issue_rd = 5'd7;
    tick();
    idle();
    bus_if.rs2_addr = 5'd7;
    #1;
    nVectors++;
    if (bus_if.rs2_busy !== 1'b1 || bus_if.busy_count !== 6'd1) begin
      nMiscompares++;
      $display("[TB] FAIL issue_r7 busy=%b count=%0d expected 1/1", bus_if.rs2_busy, bus_if.busy_count);
    end
    bus_if.wr_en = 1'b1; bus_if.wr_addr = 5'd7; bus_if.wr_data = 32'h0000_0077;
    tick();
    idle();
    #1;
    nVectors++;
    if (bus_if.rs2_busy !== 1'b0 || bus_if.busy_count !== 6'd0) begin
      nMiscompares++;
      $display("[TB] FAIL retire_r7 busy=%b count=%0d expected 0/0", bus_if.rs2_busy, bus_if.busy_count);
    end
    bus_if.issue_en = 1'b1; bus_if.issue_rd = 5'd0;
    tick();
    idle();
    bus_if.rs2_addr = 5'd0;
    #1;
    nVectors++;
    if (bus_if.busy_count !== 6'd0 || bus_if.rs2_busy !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL issue_x0 count=%0d busy=%b expected 0/0", bus_if.busy_count, bus_if.rs2_busy);
    end
  endtask

  task automatic test_same_cycle();
    bus_if.issue_en = 1'b1; bus_if.issue_rd = 5'd9;
    tick();
    bus_if.wr_en = 1'b1; bus_if.wr_addr = 5'd9; bus_if.wr_data = 32'h99;
    tick();
    idle();
    bus_if.rs1_addr = 5'd9;
    #1;
    nVectors++;
    if (bus_if.rs1_busy !== 1'b1 || bus_if.busy_count !== 6'(expCount()) || expCount() != 1) begin
      nMiscompares++;
      $display("[TB] FAIL set_wins busy=%b count=%0d expected 1/1", bus_if.rs1_busy, bus_if.busy_count);
    end
    nVectors++;
    if (bus_if.rs1_data !== 32'h99) begin
      nMiscompares++;
      $display("[TB] FAIL set_wins_data got %h expected 00000099", bus_if.rs1_data);
    end
    bus_if.wr_en = 1'b1; bus_if.wr_addr = 5'd9; bus_if.wr_data = 32'h9A;
    tick();
    idle();
  endtask

  task automatic test_bypass();
    bus_if.issue_en = 1'b1; bus_if.issue_rd = 5'd3;
    tick();
    idle();
    bus_if.rs1_addr = 5'd3;
    bus_if.wr_en = 1'b1; bus_if.wr_addr = 5'd3; bus_if.wr_data = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    nVectors++;
    if (bus_if.rs1_data !== 32'hA5A5A5A5 || bus_if.rs1_busy !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL bypass_same data=%h busy=%b expected a5a5a5a5/0", bus_if.rs1_data, bus_if.rs1_busy);
    end
`else
    nVectors++;
    if (bus_if.rs1_data !== 32'h0 || bus_if.rs1_busy !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL nobypass_same data=%h busy=%b expected 00000000/1", bus_if.rs1_data, bus_if.rs1_busy);
    end
`endif
    tick();
    idle();
    #1;
    nVectors++;
    if (bus_if.rs1_data !== 32'hA5A5A5A5 || bus_if.rs1_busy !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL bypass_next data=%h busy=%b expected a5a5a5a5/0", bus_if.rs1_data, bus_if.rs1_busy);
    end
  endtask

  task automatic test_reset_midstream();
    for (int r = 1; r <= 4; r++) begin
      bus_if.issue_en = 1'b1; bus_if.issue_rd = reg_addr_t'(r);
      tick();
    end
    idle();
    bus_if.wr_en = 1'b1; bus_if.wr_addr = 5'd2; bus_if.wr_data = 32'h55;
    tick();
    bus_if.wr_addr = 5'd4; bus_if.wr_data = 32'h4444;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) begin
      bus_if.rs1_addr = reg_addr_t'(i);
      bus_if.rs2_addr = reg_addr_t'(i);
      #1;
      nVectors++;
      if (bus_if.rs1_data !== 32'h0 || bus_if.rs2_busy !== 1'b0) begin
        nMiscompares++;
        $display("[TB] FAIL midreset addr %0d data=%h busy=%b expected 0/0", i, bus_if.rs1_data, bus_if.rs2_busy);
      end
    end
    nVectors++;
    if (bus_if.busy_count !== 6'd0) begin
      nMiscompares++;
      $display("[TB] FAIL midreset_count got %0d expected 0", bus_if.busy_count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst             = ($urandom_range(99, 0) == 0);
      bus_if.wr_en    = $urandom_range(1, 0) == 1;
      bus_if.wr_addr  = reg_addr_t'($urandom_range(31, 0));
      bus_if.wr_data  = xword_t'($urandom());
      bus_if.issue_en = $urandom_range(2, 0) == 0;
      bus_if.issue_rd = reg_addr_t'($urandom_range(31, 0));
      bus_if.rs1_addr = ($urandom_range(3, 0) == 0) ? bus_if.wr_addr : reg_addr_t'($urandom_range(31, 0));
      bus_if.rs2_addr = reg_addr_t'($urandom_range(31, 0));
      #1;
      nVectors++;
      if (bus_if.rs1_data !== expData(bus_if.rs1_addr) || bus_if.rs1_busy !== expBusy(bus_if.rs1_addr)) begin
        nMiscompares++;
        $display("[TB] FAIL rand_rs1 cyc %0d addr %0d got %h/%b expected %h/%b", c, bus_if.rs1_addr,
                 bus_if.rs1_data, bus_if.rs1_busy, expData(bus_if.rs1_addr), expBusy(bus_if.rs1_addr));
      end
      nVectors++;
      if (bus_if.rs2_data !== expData(bus_if.rs2_addr) || bus_if.rs2_busy !== expBusy(bus_if.rs2_addr)) begin
        nMiscompares++;
        $display("[TB] FAIL rand_rs2 cyc %0d addr %0d got %h/%b expected %h/%b", c, bus_if.rs2_addr,
                 bus_if.rs2_data, bus_if.rs2_busy, expData(bus_if.rs2_addr), expBusy(bus_if.rs2_addr));
      end
      nVectors++;
      if (bus_if.busy_count !== 6'(expCount())) begin
        nMiscompares++;
        $display("[TB] FAIL rand_count cyc %0d got %0d expected %0d", c, bus_if.busy_count, expCount());
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    rst          = 1'b0;
    idle();
    bus_if.rs1_addr = '0;
    bus_if.rs2_addr = '0;
    foreach (mRegs[i]) begin
      mRegs[i] = '0;
      mBusy[i] = 1'b0;
    end
    test_reset();
    test_write();
    test_scoreboard();
    test_same_cycle();
    test_bypass();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
